// File: rtl/muldiv_unit_pkg.sv
// muldiv_unit_pkg: shared constants for the iterative multiply/divide unit.
//   - MD_* opcode values presented on the unit's op port
//   - MD_IDLE/MD_RUN/MD_FIX controller state encodings
//   - MIPS funct codes for mult/div and the HI/LO move instructions
//   - small opcode decode helpers
package muldiv_unit_pkg;

  localparam logic [1:0] MD_MULT  = 2'd0;
  localparam logic [1:0] MD_MULTU = 2'd1;
  localparam logic [1:0] MD_DIV   = 2'd2;
  localparam logic [1:0] MD_DIVU  = 2'd3;

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_RUN  = 2'd1,
    MD_FIX  = 2'd2
  } md_state_e;

  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;

  // Signed variants take operand magnitudes; unsigned variants use raw bits.
  function automatic logic md_is_signed(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  function automatic logic md_is_div(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/muldiv_unit_cond_negate.sv
// cond_negate: conditional two's-complement negation.
//   in  [N-1:0]  value
//   neg          1 = output -in, 0 = pass through
//   out [N-1:0]  result (negating the most negative value wraps to itself)
module cond_negate #(
  parameter int N = 32
) (
  input  logic [N-1:0] in,
  input  logic         neg,
  output logic [N-1:0] out
);

  assign out = neg ? ((~in) + N'(1)) : in;

endmodule

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative multiply/divide with architectural HI/LO registers.
// One operation takes N+1 cycles: N shift iterations plus a sign-fixup cycle.
//   clock, reset      clock (posedge), asynchronous active-low reset
//   start, op         request and opcode, sampled only while idle
//   inA, inB          multiplicand/dividend, multiplier/divisor
//   hi_wen, lo_wen,wd direct HI/LO writes (mthi/mtlo), honoured only while idle
//   busy              operation in progress (registered)
//   done              one-cycle completion pulse
//   div_by_zero       last divide had a zero divisor; valid from done to next start
//   hi, lo            architectural HI/LO registers
module muldiv_unit
  import muldiv_unit_pkg::*;
#(
  parameter int N  = 32,
  parameter int CW = 6
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] inA,
  input  logic [N-1:0] inB,
  input  logic         hi_wen,
  input  logic         lo_wen,
  input  logic [N-1:0] wd,
  output logic         busy,
  output logic         done,
  output logic         div_by_zero,
  output logic [N-1:0] hi,
  output logic [N-1:0] lo
);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic             sa_q, sa_d;
  logic             sb_q, sb_d;
  // Multiplicand for multiply, divisor for divide.
  logic [N-1:0]     opnd_q, opnd_d;
  // Multiply: {partial product, remaining multiplier bits}.
  // Divide:   {partial remainder, dividend bits shifting into quotient}.
  logic [2*N-1:0]   acc_q, acc_d;
  logic [N-1:0]     hi_q, hi_d;
  logic [N-1:0]     lo_q, lo_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic             a_neg, b_neg;
  logic [N-1:0]     a_mag, b_mag;
  logic [N:0]       mul_sum;
  logic [2*N-1:0]   mul_next;
  logic [N:0]       div_shift;
  logic [N:0]       div_diff;
  logic [2*N-1:0]   div_next;
  logic [2*N-1:0]   prod_fix;
  logic [N-1:0]     quot_fix;
  logic [N-1:0]     rem_fix;
  logic             dbz_now;

  assign a_neg = md_is_signed(op) & inA[N-1];
  assign b_neg = md_is_signed(op) & inB[N-1];

  cond_negate #(.N(N)) u_mag_a (.in(inA), .neg(a_neg), .out(a_mag));
  cond_negate #(.N(N)) u_mag_b (.in(inB), .neg(b_neg), .out(b_mag));

  // Shift-add step: add multiplicand when the current multiplier bit is set,
  // then shift the whole accumulator right, keeping the carry.
  assign mul_sum  = {1'b0, acc_q[2*N-1:N]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[N-1:1]};

  // Restoring divide step: shift the next dividend bit into the remainder and
  // keep the subtraction only when it does not go negative.
  assign div_shift = {acc_q[2*N-1:N], acc_q[N-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_next  = div_diff[N] ? {div_shift[N-1:0], acc_q[N-2:0], 1'b0}
                                 : {div_diff[N-1:0],  acc_q[N-2:0], 1'b1};

  // A zero divisor never fails the subtraction, so the remainder ends up as the
  // dividend magnitude; re-applying the dividend sign restores inA exactly.
  cond_negate #(.N(2*N)) u_fix_prod (.in(acc_q),            .neg(sa_q ^ sb_q), .out(prod_fix));
  cond_negate #(.N(N))   u_fix_quot (.in(acc_q[N-1:0]),     .neg(sa_q ^ sb_q), .out(quot_fix));
  cond_negate #(.N(N))   u_fix_rem  (.in(acc_q[2*N-1:N]),   .neg(sa_q),        .out(rem_fix));

  assign dbz_now = (opnd_q == '0);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    dbz_d   = dbz_q;
    case (state_q)
      MD_IDLE: begin
        if (hi_wen) hi_d = wd;
        if (lo_wen) lo_d = wd;
        if (start) begin
          op_d    = op;
          sa_d    = a_neg;
          sb_d    = b_neg;
          opnd_d  = md_is_div(op) ? b_mag : a_mag;
          acc_d   = {{N{1'b0}}, (md_is_div(op) ? a_mag : b_mag)};
          cnt_d   = '0;
          dbz_d   = 1'b0;
          state_d = MD_RUN;
        end
      end
      MD_RUN: begin
        acc_d = md_is_div(op_q) ? div_next : mul_next;
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(N - 1)) state_d = MD_FIX;
      end
      MD_FIX: begin
        if (md_is_div(op_q)) begin
          lo_d  = dbz_now ? '1 : quot_fix;
          hi_d  = rem_fix;
          dbz_d = dbz_now;
        end else begin
          {hi_d, lo_d} = prod_fix;
        end
        done_d  = 1'b1;
        state_d = MD_IDLE;
      end
      default: state_d = MD_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= MD_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      sa_q    <= 1'b0;
      sb_q    <= 1'b0;
      opnd_q  <= '0;
      acc_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // busy comes straight from the state register, never from start.
  assign busy        = (state_q != MD_IDLE);
  assign done        = done_q;
  assign div_by_zero = dbz_q;
  assign hi          = hi_q;
  assign lo          = lo_q;

endmodule
